// File: rtl/msrv32_trap_sequencer.sv
// Machine-mode trap sequencer: prioritises exceptions/interrupts, sequences the
// CSR-file trap strobes, and selects the PC source and fetch flush.
module msrv32_trap_sequencer (
  input  logic       clock,
  input  logic       rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       mret_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       misaligned_exception_out,
  output logic       instret_inc_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out
);

  typedef enum logic [1:0] {
    RESET       = 2'b00,
    OPERATING   = 2'b01,
    TRAP_TAKEN  = 2'b10,
    TRAP_RETURN = 2'b11
  } state_t;

  state_t     state, next_state;
  logic [3:0] cause_q;
  logic       irq_q;
  logic       exc, irq, take_trap;
  logic [3:0] trap_cause;

  always_comb begin
    exc = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
          misaligned_store_in | ecall_in | ebreak_in;
    irq = mie_in & ((meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in));
    take_trap = exc | irq;

    // Exceptions first, then interrupts; the final default is the timer
    // interrupt, which is the only remaining source once irq is known true.
    if (ebreak_in)                 trap_cause = 4'd3;
    else if (misaligned_instr_in)  trap_cause = 4'd0;
    else if (illegal_instr_in)     trap_cause = 4'd2;
    else if (ecall_in)             trap_cause = 4'd11;
    else if (misaligned_load_in)   trap_cause = 4'd4;
    else if (misaligned_store_in)  trap_cause = 4'd6;
    else if (meie_in & meip_in)    trap_cause = 4'd11;
    else if (msie_in & msip_in)    trap_cause = 4'd3;
    else                           trap_cause = 4'd7;
  end

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      state   <= RESET;
      cause_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == OPERATING && take_trap) begin
        cause_q <= trap_cause;
        irq_q   <= ~exc;
      end
    end
  end

  always_comb begin
    next_state               = state;
    pc_src_out               = 2'b00;
    flush_out                = 1'b1;
    set_cause_out            = 1'b0;
    set_epc_out              = 1'b0;
    mie_clear_out            = 1'b0;
    mie_set_out              = 1'b0;
    misaligned_exception_out = 1'b0;
    instret_inc_out          = 1'b0;
    i_or_e_out               = irq_q;
    cause_out                = cause_q;

    unique case (state)
      RESET: begin
        next_state = OPERATING;
      end
      OPERATING: begin
        pc_src_out      = 2'b11;
        flush_out       = 1'b0;
        instret_inc_out = ~(take_trap | mret_in);
        if (take_trap)    next_state = TRAP_TAKEN;
        else if (mret_in) next_state = TRAP_RETURN;
      end
      TRAP_TAKEN: begin
        next_state               = OPERATING;
        pc_src_out               = 2'b10;
        set_cause_out            = 1'b1;
        set_epc_out              = 1'b1;
        mie_clear_out            = 1'b1;
        misaligned_exception_out = ~irq_q &
          (cause_q == 4'd0 || cause_q == 4'd4 || cause_q == 4'd6);
      end
      TRAP_RETURN: begin
        next_state  = OPERATING;
        pc_src_out  = 2'b01;
        mie_set_out = 1'b1;
      end
      default: next_state = RESET;
    endcase
  end

endmodule

// File: tb/tb_msrv32_trap_sequencer.sv
// Randomized self-checking bench for msrv32_trap_sequencer against a
// cycle-level behavioural model of the trap rules.
module tb_msrv32_trap_sequencer;

  logic clock = 1'b0;
  logic rst_in = 1'b1;
  always #5 clock = ~clock;

  typedef struct packed {
    logic illegal, mis_instr, mis_load, mis_store, ecall, ebreak, mret;
    logic mie, meie, mtie, msie, meip, mtip, msip;
  } stim_t;

  stim_t s = '0;

  logic       i_or_e_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out;
  logic       misaligned_exception_out, instret_inc_out, flush_out;
  logic [3:0] cause_out;
  logic [1:0] pc_src_out;

  msrv32_trap_sequencer dut (
    .clock(clock), .rst_in(rst_in),
    .illegal_instr_in(s.illegal), .misaligned_instr_in(s.mis_instr),
    .misaligned_load_in(s.mis_load), .misaligned_store_in(s.mis_store),
    .ecall_in(s.ecall), .ebreak_in(s.ebreak), .mret_in(s.mret),
    .mie_in(s.mie), .meie_in(s.meie), .mtie_in(s.mtie), .msie_in(s.msie),
    .meip_in(s.meip), .mtip_in(s.mtip), .msip_in(s.msip),
    .i_or_e_out(i_or_e_out), .cause_out(cause_out),
    .set_cause_out(set_cause_out), .set_epc_out(set_epc_out),
    .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .misaligned_exception_out(misaligned_exception_out),
    .instret_inc_out(instret_inc_out), .pc_src_out(pc_src_out),
    .flush_out(flush_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Model: what the sequencer owes on the current cycle.
  bit         in_reset = 1'b1;
  bit         trap_pending = 1'b0;
  bit         ret_pending = 1'b0;
  logic [3:0] m_cause = '0;
  bit         m_irq = 1'b0;

  function automatic void classify(input stim_t st, output bit is_exc, output bit is_irq,
                                   output logic [3:0] code);
    bit         ef[6];
    logic [3:0] ec[6];
    bit         inf[3];
    logic [3:0] ic[3];
    ef = '{st.ebreak, st.mis_instr, st.illegal, st.ecall, st.mis_load, st.mis_store};
    ec = '{4'd3, 4'd0, 4'd2, 4'd11, 4'd4, 4'd6};
    inf = '{st.meie & st.meip, st.msie & st.msip, st.mtie & st.mtip};
    ic = '{4'd11, 4'd3, 4'd7};
    is_exc = 1'b0;
    is_irq = 1'b0;
    code = '0;
    for (int i = 5; i >= 0; i--) if (ef[i]) begin is_exc = 1'b1; code = ec[i]; end
    if (!is_exc && st.mie)
      for (int i = 2; i >= 0; i--) if (inf[i]) begin is_irq = 1'b1; code = ic[i]; end
  endfunction

  function automatic logic [15:0] pack_obs();
    return {2'b00, pc_src_out, flush_out, set_cause_out, set_epc_out, mie_clear_out,
            mie_set_out, misaligned_exception_out, instret_inc_out, i_or_e_out, cause_out};
  endfunction

  task automatic cycle(input stim_t st, input bit r, input string tag);
    bit         e, q;
    logic [3:0] c;
    logic [1:0] pc;
    bit fl, sc, mc, ms, mx, ir;
    @(negedge clock);
    s = st;
    rst_in = r;
    if (r) begin
      in_reset = 1'b1; trap_pending = 1'b0; ret_pending = 1'b0;
      m_cause = '0; m_irq = 1'b0;
    end
    #1;
    classify(st, e, q, c);
    {sc, mc, ms, mx, ir} = '0;
    fl = 1'b1;
    if (in_reset)          pc = 2'd0;
    else if (trap_pending) begin
      pc = 2'd2; sc = 1'b1; mc = 1'b1;
      mx = !m_irq && (m_cause == 4'd0 || m_cause == 4'd4 || m_cause == 4'd6);
    end
    else if (ret_pending)  begin pc = 2'd1; ms = 1'b1; end
    else begin pc = 2'd3; fl = 1'b0; ir = !(e || q || st.mret); end
    check_eq(tag, pack_obs(), {2'b00, pc, fl, sc, sc, mc, ms, mx, ir, m_irq, m_cause});
    if (in_reset) begin
      if (!r) in_reset = 1'b0;
    end else if (trap_pending || ret_pending) begin
      trap_pending = 1'b0; ret_pending = 1'b0;
    end else if (e || q) begin
      trap_pending = 1'b1; m_cause = c; m_irq = q;
    end else if (st.mret) ret_pending = 1'b1;
  endtask

  function automatic stim_t rand_stim();
    stim_t st;
    st.illegal   = ($urandom_range(0, 11) == 0);
    st.mis_instr = ($urandom_range(0, 11) == 0);
    st.mis_load  = ($urandom_range(0, 11) == 0);
    st.mis_store = ($urandom_range(0, 11) == 0);
    st.ecall     = ($urandom_range(0, 11) == 0);
    st.ebreak    = ($urandom_range(0, 11) == 0);
    st.mret      = ($urandom_range(0, 5) == 0);
    st.mie       = 1'($urandom);
    st.meie      = 1'($urandom);
    st.mtie      = 1'($urandom);
    st.msie      = 1'($urandom);
    st.meip      = ($urandom_range(0, 3) == 0);
    st.mtip      = ($urandom_range(0, 3) == 0);
    st.msip      = ($urandom_range(0, 3) == 0);
    return st;
  endfunction

  stim_t z, t;

  initial begin
    z = '0;
    repeat (3) cycle(z, 1'b1, "reset_hold");
    cycle(z, 1'b0, "reset_release");
    cycle(z, 1'b0, "first_retire");
    check_eq("first_pc_src", {14'd0, pc_src_out}, 16'd3);
    check_eq("first_instret", {15'd0, instret_inc_out}, 16'd1);

    t = z; t.ebreak = 1; t.illegal = 1;
    cycle(t, 1'b0, "ebrk_ill_detect");
    cycle(z, 1'b0, "ebrk_ill_taken");
    check_eq("ebrk_cause", {12'd0, cause_out}, 16'd3);
    check_eq("ebrk_ioe", {15'd0, i_or_e_out}, 16'd0);

    t = z; t.mis_load = 1; t.mtie = 1; t.mtip = 1; t.mie = 1;
    cycle(t, 1'b0, "ld_tmr_detect");
    cycle(t, 1'b0, "ld_tmr_taken");
    check_eq("ld_misaligned", {15'd0, misaligned_exception_out}, 16'd1);
    t.mis_load = 0;
    cycle(t, 1'b0, "tmr_detect");
    cycle(z, 1'b0, "tmr_taken");
    check_eq("tmr_cause", {12'd0, cause_out}, 16'd7);
    check_eq("tmr_ioe", {15'd0, i_or_e_out}, 16'd1);

    t = z; t.meie = 1; t.mtie = 1; t.msie = 1; t.meip = 1; t.mtip = 1; t.msip = 1;
    t.mie = 0;
    cycle(t, 1'b0, "irq_masked");
    check_eq("masked_instret", {15'd0, instret_inc_out}, 16'd1);
    t.mie = 1;
    cycle(t, 1'b0, "irq_all_detect");
    cycle(z, 1'b0, "irq_all_taken");
    check_eq("ext_cause", {12'd0, cause_out}, 16'd11);

    t = z; t.mret = 1;
    cycle(t, 1'b0, "mret_detect");
    cycle(t, 1'b0, "mret_return");
    check_eq("mret_mie_set", {15'd0, mie_set_out}, 16'd1);
    t = z; t.mret = 1; t.ecall = 1;
    cycle(t, 1'b0, "mret_ecall_detect");
    cycle(z, 1'b0, "mret_ecall_taken");
    check_eq("ecall_cause", {12'd0, cause_out}, 16'd11);

    t = z; t.ecall = 1;
    cycle(t, 1'b0, "pre_abort");
    cycle(z, 1'b1, "abort_mid_trap");
    check_eq("abort_cause", {12'd0, cause_out}, 16'd0);
    cycle(z, 1'b0, "abort_release");
    cycle(z, 1'b0, "abort_resume");

    for (int n = 0; n < 3000; n++)
      cycle(rand_stim(), ($urandom_range(0, 149) == 0), "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_trap_sequencer.md
# msrv32_trap_sequencer

Machine-mode trap sequencer for the MSRV32 core. It watches decode and execute exception flags and the interrupt-enable and pending bits exported by the CSR file, and picks the highest-priority trap. It then drives the CSR file's trap strobes (`set_cause`, `set_epc`, `mie_clear`, `mie_set`, `i_or_e`, `cause`, `instret_inc`) and the PC-source select and pipeline flush for the fetch stage. It sits between the decoder/branch unit and `msrv32_csr_file`, and is the only writer of those CSR-file control inputs.

## Interface
- No parameters.
- `clock`  in  1  sole clock, rising edge
- `rst_in`  in  1  asynchronous, active-high reset
- `illegal_instr_in`  in  1  decoder: illegal opcode
- `misaligned_instr_in`  in  1  branch/jump target misaligned
- `misaligned_load_in`  in  1  load address misaligned
- `misaligned_store_in`  in  1  store address misaligned
- `ecall_in`, `ebreak_in`, `mret_in`  in  1 each  decoded system instructions
- `mie_in`  in  1  mstatus.MIE from CSR file
- `meie_in`, `mtie_in`, `msie_in`  in  1 each  mie register enables
- `meip_in`, `mtip_in`, `msip_in`  in  1 each  mip register pending bits
- `i_or_e_out`  out  1  1 = interrupt, 0 = exception (to CSR `i_or_e_in`)
- `cause_out`  out  4  trap cause code (to CSR `cause_in`)
- `set_cause_out`, `set_epc_out`  out  1 each  capture mcause/mtval and mepc
- `mie_clear_out`, `mie_set_out`  out  1 each  mstatus.MIE clear on trap, restore on mret
- `misaligned_exception_out`  out  1  mtval captures `iadder`
- `instret_inc_out`  out  1  retire strobe
- `pc_src_out`  out  2  00 boot, 01 epc, 10 trap address, 11 next PC
- `flush_out`  out  1  kill the instruction in the fetch/decode stage

## Operation
- FSM has four states: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN. It encodes the state in 2 bits and registers it.
- Outputs are combinational decodes of the current state, plus the latched cause registers `cause_q[3:0]` and `irq_q`.
- Detection happens in OPERATING only:
  - `exc = illegal | misaligned_instr | misaligned_load | misaligned_store | ecall | ebreak`
  - `irq = mie_in & ((meie&meip) | (msie&msip) | (mtie&mtip))`
- Exception priority, highest first, with cause code: ebreak 3, misaligned_instr 0, illegal 2, ecall 11, misaligned_load 4, misaligned_store 6.
- Interrupt priority, highest first, with cause code: external 11, software 3, timer 7.
- Exceptions always beat interrupts in the same cycle. A trap (exception or interrupt) beats `mret_in`.
- Transitions:
  - RESET -> OPERATING: unconditional.
  - OPERATING -> TRAP_TAKEN on `exc|irq`. Latches `cause_q`. Latches `irq_q = ~exc`.
  - OPERATING -> TRAP_RETURN on `mret_in` when there is no trap.
  - Otherwise OPERATING holds.
  - TRAP_TAKEN -> OPERATING: unconditional.
  - TRAP_RETURN -> OPERATING: unconditional.
- Outputs per state:
  - RESET: `pc_src = 00`, `flush = 1`, all strobes 0.
  - OPERATING: `pc_src = 11`, `flush = 0`. `instret_inc = ~(exc|irq|mret_in)`.
  - TRAP_TAKEN: `pc_src = 10`, `flush = 1`. `set_cause = set_epc = mie_clear = 1`. `i_or_e = irq_q`, `cause = cause_q`. `misaligned_exception = ~irq_q & (cause_q ∈ {0,4,6})`.
  - TRAP_RETURN: `pc_src = 01`, `flush = 1`, `mie_set = 1`.
- `i_or_e_out` and `cause_out` always reflect `irq_q`/`cause_q`, so they hold steady outside TRAP_TAKEN.
- Interrupts are level-sensitive. A source that is still pending and enabled after `mret` is taken again on the first OPERATING cycle after TRAP_RETURN.

## Timing
- `rst_in` is asynchronous and active-high. While it is asserted:
  - state = RESET, `cause_q = 0`, `irq_q = 0`.
  - `pc_src_out = 00`, `flush_out = 1`.
  - `set_cause_out`, `set_epc_out`, `mie_clear_out`, `mie_set_out`, `misaligned_exception_out`, `instret_inc_out`, `i_or_e_out` are all 0; `cause_out = 0`.
- After reset is released: the first rising edge enters OPERATING. Normal retire begins on that cycle.
- Trap latency: the flag is sampled in OPERATING on cycle N. TRAP_TAKEN is on cycle N+1, with exactly one cycle of strobes and `pc_src = 10`. OPERATING resumes on N+2.
- `mret` latency matches trap latency: TRAP_RETURN for exactly one cycle, `mie_set` pulses once.
- The CSR file samples all strobes on the same rising edge that leaves TRAP_TAKEN or TRAP_RETURN.
- Exception and mret flags asserted in TRAP_TAKEN, TRAP_RETURN or RESET are ignored. The flushed instruction does not retire.
- Reset asserted mid-trap aborts immediately. No strobe may be seen on the edge that follows.

## Test plan
- Reset: hold `rst_in` for 3 cycles -> `pc_src = 00`, `flush = 1`, every strobe 0. The first cycle after release shows `pc_src = 11`, `instret_inc = 1`.
- Simultaneous `ebreak_in` and `illegal_instr_in` at cycle N -> cycle N+1 shows `cause = 3`, `i_or_e = 0`, `set_cause = set_epc = mie_clear = 1`, `pc_src = 10`, `misaligned_exception = 0`.
- `misaligned_load_in` with `mtip` enabled and pending and `mie_in = 1` -> `cause = 4`, `i_or_e = 0`, `misaligned_exception = 1`. The next OPERATING cycle then takes the timer trap with `cause = 7`, `i_or_e = 1`.
- `meip`, `msip`, `mtip` all pending and enabled, `mie_in = 1` -> `cause = 11`, `i_or_e = 1`. The same stimulus with `mie_in = 0` -> no trap and `instret_inc = 1`.
- `mret_in` alone -> one cycle with `pc_src = 01`, `mie_set = 1`, `flush = 1`, `instret_inc = 0` on the detect cycle. `mret_in` together with `ecall_in` -> trap with `cause = 11` and no `mie_set`.
- Assert `rst_in` during TRAP_TAKEN -> outputs return to reset values asynchronously and `cause_out` reads 0.
